// File: rtl/cfr_axil_ipif.sv
// cfr_axil_ipif: AXI4-Lite slave bridged onto the CFR IPIF with per-path ack timeout
module cfr_axil_ipif #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH+1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH+1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic                    wr_req,
  output logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_ack,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_req,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_ack
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] W_IDLE = 2'd0, W_REQ = 2'd1, W_WAIT = 2'd2, W_RESP = 2'd3;
  localparam logic [1:0] R_IDLE = 2'd0, R_REQ = 2'd1, R_WAIT = 2'd2, R_RESP = 2'd3;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  logic [1:0] w_state, r_state;
  logic aw_got, w_got, strb_ok;
  logic [ADDR_WIDTH-1:0] aw_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [CW-1:0] w_cnt, r_cnt;
  logic aw_hs, w_hs, ar_hs, unused;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign wr_req = (w_state == W_REQ) & strb_ok;
  assign rd_req = r_state == R_REQ;
  assign s_axi_bvalid = w_state == W_RESP;
  assign s_axi_rvalid = r_state == R_RESP;
  assign unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  // AW and W are parked in aw_q/wd_q so the IPIF outputs only move on the IDLE->REQ step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      strb_ok <= 1'b0;
      aw_q <= '0;
      wd_q <= '0;
      w_cnt <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bresp <= 2'b00;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) aw_q <= s_axi_awaddr[ADDR_WIDTH+1:2];
          if (w_hs) begin
            wd_q <= s_axi_wdata;
            strb_ok <= s_axi_wstrb == 4'hF;
          end
          if ((aw_got | aw_hs) & (w_got | w_hs)) begin
            w_state <= W_REQ;
            aw_got <= 1'b0;
            w_got <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready <= 1'b0;
            wr_addr <= aw_hs ? s_axi_awaddr[ADDR_WIDTH+1:2] : aw_q;
            wr_data <= w_hs ? s_axi_wdata : wd_q;
          end else begin
            aw_got <= aw_got | aw_hs;
            w_got <= w_got | w_hs;
            s_axi_awready <= ~(aw_got | aw_hs);
            s_axi_wready <= ~(w_got | w_hs);
          end
        end
        W_REQ: begin
          w_cnt <= '0;
          w_state <= (!strb_ok || wr_ack) ? W_RESP : W_WAIT;
          if (!strb_ok || wr_ack) s_axi_bresp <= strb_ok ? 2'b00 : 2'b10;
        end
        W_WAIT: begin
          w_cnt <= w_cnt + CW'(1);
          if (wr_ack || w_cnt == T_LAST) begin
            w_state <= W_RESP;
            s_axi_bresp <= wr_ack ? 2'b00 : 2'b10;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready <= 1'b1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_cnt <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
      rd_addr <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= ~ar_hs;
          if (ar_hs) begin
            r_state <= R_REQ;
            rd_addr <= s_axi_araddr[ADDR_WIDTH+1:2];
          end
        end
        R_REQ: begin
          r_cnt <= '0;
          r_state <= rd_ack ? R_RESP : R_WAIT;
          if (rd_ack) begin
            s_axi_rdata <= rd_data;
            s_axi_rresp <= 2'b00;
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (rd_ack || r_cnt == T_LAST) begin
            r_state <= R_RESP;
            s_axi_rdata <= rd_ack ? rd_data : '0;
            s_axi_rresp <= rd_ack ? 2'b00 : 2'b10;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            r_state <= R_IDLE;
            s_axi_arready <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cfr_axil_ipif.sv
// tb_cfr_axil_ipif: directed checks of the AXI4-Lite to CFR IPIF bridge
module tb_cfr_axil_ipif;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0, rd_data = '0;
  logic [3:0] wstrb = 4'hF;
  logic wr_ack = 0, rd_ack = 0;
  logic awready, wready, bvalid, arready, rvalid, wr_req, rd_req;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, wr_data;
  logic [9:0] wr_addr, rd_addr;
  int total = 0, bad = 0, wr_cnt = 0, rd_cnt = 0, n, w0;

  cfr_axil_ipif dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .wr_addr(wr_addr), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (wr_req) wr_cnt++;
    if (rd_req) rd_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_b(output int cyc);
    cyc = 0;
    while (!bvalid && cyc < 64) begin tick(); cyc++; end
    if (cyc >= 64) chk("bvalid_timeout", 32'(bvalid), 32'd1);
  endtask

  task automatic wait_r(output int cyc);
    cyc = 0;
    while (!rvalid && cyc < 64) begin tick(); cyc++; end
    if (cyc >= 64) chk("rvalid_timeout", 32'(rvalid), 32'd1);
  endtask

  task automatic b_hs;
    bready = 1; tick(); bready = 0;
  endtask

  task automatic r_hs;
    rready = 1; tick(); rready = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int ack_dly);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    if (ack_dly >= 0) begin
      repeat (ack_dly) tick();
      wr_ack = 1; tick(); wr_ack = 0;
    end
    wait_b(n);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input int ack_dly);
    araddr = a; arvalid = 1;
    tick();
    arvalid = 0;
    repeat (ack_dly) tick();
    rd_ack = 1; rd_data = d; tick(); rd_ack = 0; rd_data = 32'hDEAD_BEEF;
    wait_r(n);
  endtask

  initial begin
    #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rdata", rdata, 0);
    tick(); tick();
    rst = 0;
    tick();
    chk("post_rst_awready", 32'(awready), 1);
    chk("post_rst_wready", 32'(wready), 1);
    chk("post_rst_arready", 32'(arready), 1);
    // same-cycle AW/W, ack one cycle after req
    w0 = wr_cnt;
    awaddr = 12'h024; wdata = 32'h0001_2345; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("t1_wr_req", 32'(wr_req), 1);
    chk("t1_wr_addr", 32'(wr_addr), 9);
    chk("t1_wr_data", wr_data, 32'h0001_2345);
    chk("t1_awready_low", 32'(awready), 0);
    tick();
    chk("t1_wr_req_c2", 32'(wr_req), 0);
    chk("t1_bvalid_c2", 32'(bvalid), 0);
    wr_ack = 1; tick(); wr_ack = 0;
    chk("t1_bvalid_c3", 32'(bvalid), 1);
    chk("t1_bresp", 32'(bresp), 0);
    chk("t1_wr_pulses", 32'(wr_cnt - w0), 1);
    b_hs();
    chk("t1_bvalid_after", 32'(bvalid), 0);
    chk("t1_awready_back", 32'(awready), 1);
    chk("t1_wready_back", 32'(wready), 1);
    // W four cycles ahead of AW
    w0 = wr_cnt;
    wdata = 32'h0000_1234; wvalid = 1;
    tick();
    wvalid = 0;
    chk("t2_wready_drop", 32'(wready), 0);
    chk("t2_awready_hold", 32'(awready), 1);
    repeat (3) tick();
    chk("t2_no_req_yet", 32'(wr_cnt - w0), 0);
    awaddr = 12'h800; awvalid = 1;
    tick();
    awvalid = 0;
    chk("t2_wr_req", 32'(wr_req), 1);
    chk("t2_wr_addr", 32'(wr_addr), 512);
    chk("t2_wr_data", wr_data, 32'h0000_1234);
    tick();
    wr_ack = 1; tick(); wr_ack = 0;
    chk("t2_bvalid", 32'(bvalid), 1);
    chk("t2_bresp", 32'(bresp), 0);
    chk("t2_wr_pulses", 32'(wr_cnt - w0), 1);
    b_hs();
    // partial strobe
    w0 = wr_cnt;
    wr(12'h010, 32'hCAFE_0000, 4'b0011, -1);
    chk("t3_bresp", 32'(bresp), 2);
    chk("t3_no_req", 32'(wr_cnt - w0), 0);
    b_hs();
    wr(12'h010, 32'hCAFE_0001, 4'hF, 0);
    chk("t3_next_bresp", 32'(bresp), 0);
    chk("t3_next_req", 32'(wr_cnt - w0), 1);
    b_hs();
    // read with delayed ack and rready held low
    araddr = 12'h000; arvalid = 1;
    tick();
    arvalid = 0;
    chk("t4_rd_req", 32'(rd_req), 1);
    chk("t4_rd_addr", 32'(rd_addr), 0);
    tick(); tick();
    rd_ack = 1; rd_data = 32'h0000_0005; tick(); rd_ack = 0; rd_data = 32'hDEAD_BEEF;
    chk("t4_rvalid", 32'(rvalid), 1);
    chk("t4_rdata", rdata, 5);
    chk("t4_rresp", 32'(rresp), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_rvalid_hold", 32'(rvalid), 1);
      chk("t4_rdata_hold", rdata, 5);
      chk("t4_arready_low", 32'(arready), 0);
    end
    r_hs();
    chk("t4_rvalid_done", 32'(rvalid), 0);
    chk("t4_arready_back", 32'(arready), 1);
    // timeouts on both paths together
    awaddr = 12'h040; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 12'h044; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    n = 0;
    while (!(bvalid && rvalid) && n < 64) begin tick(); n++; end
    chk("t5_cycles", 32'(n), 17);
    chk("t5_bresp", 32'(bresp), 2);
    chk("t5_rresp", 32'(rresp), 2);
    chk("t5_rdata", rdata, 0);
    wr_ack = 1; rd_ack = 1; rd_data = 32'h7777_7777; tick(); wr_ack = 0; rd_ack = 0;
    chk("t5_late_bresp", 32'(bresp), 2);
    chk("t5_late_rresp", 32'(rresp), 2);
    chk("t5_late_rdata", rdata, 0);
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    wr(12'h048, 32'h3333_4444, 4'hF, 1);
    chk("t5_after_bresp", 32'(bresp), 0);
    b_hs();
    rd(12'h04C, 32'hA5A5_0001, 1);
    chk("t5_after_rresp", 32'(rresp), 0);
    chk("t5_after_rdata", rdata, 32'hA5A5_0001);
    chk("t5_after_rd_addr", 32'(rd_addr), 32'h13);
    r_hs();
    // asynchronous reset with both paths mid-wait
    awaddr = 12'h0F0; wdata = 32'h5555_6666; awvalid = 1; wvalid = 1;
    araddr = 12'h0F4; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    tick();
    #2 rst = 1;
    #1;
    chk("t6_wr_addr", 32'(wr_addr), 0);
    chk("t6_wr_data", wr_data, 0);
    chk("t6_rd_addr", 32'(rd_addr), 0);
    chk("t6_rdata", rdata, 0);
    chk("t6_rdy", {29'd0, awready, wready, arready}, 0);
    chk("t6_req", {30'd0, wr_req, rd_req}, 0);
    tick(); tick();
    rst = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bvalid || rvalid) n++;
    end
    chk("t6_no_resp", 32'(n), 0);
    w0 = wr_cnt;
    wr(12'h0F8, 32'h9999_0000, 4'hF, 1);
    chk("t6_post_bresp", 32'(bresp), 0);
    chk("t6_post_wr_addr", 32'(wr_addr), 32'h3E);
    chk("t6_post_req", 32'(wr_cnt - w0), 1);
    b_hs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cfr_axil_ipif.md
# cfr_axil_ipif

AXI4-Lite slave to IPIF bridge sitting directly upstream of the CFR register block. Converts AXI4-Lite write and read transactions into single-cycle `wr_req`/`rd_req` pulses on the CFR IPIF, waits for `wr_ack`/`rd_ack`, and returns the AXI response. Write and read paths are independent FSMs. A per-path timeout guarantees an AXI response even if the register block never acknowledges.

## Interface
- `ADDR_WIDTH`, 10, IPIF word-address width; AXI byte address is `ADDR_WIDTH+2` bits.
- `DATA_WIDTH`, 32, data width; fixed at 32 for AXI4-Lite.
- `TIMEOUT`, 16, maximum wait cycles for an ack before an error response (≥1).

Ports:
- `clk`  in  1  single clock for AXI and IPIF sides.
- `rst`  in  1  reset; asynchronous, active-high.
- `s_axi_awaddr` in ADDR_WIDTH+2; `s_axi_awvalid` in 1; `s_axi_awready` out 1.
- `s_axi_wdata` in 32; `s_axi_wstrb` in 4; `s_axi_wvalid` in 1; `s_axi_wready` out 1.
- `s_axi_bresp` out 2; `s_axi_bvalid` out 1; `s_axi_bready` in 1.
- `s_axi_araddr` in ADDR_WIDTH+2; `s_axi_arvalid` in 1; `s_axi_arready` out 1.
- `s_axi_rdata` out 32; `s_axi_rresp` out 2; `s_axi_rvalid` out 1; `s_axi_rready` in 1.
- `wr_addr` out ADDR_WIDTH; `wr_req` out 1; `wr_data` out 32; `wr_ack` in 1.
- `rd_addr` out ADDR_WIDTH; `rd_req` out 1; `rd_data` in 32; `rd_ack` in 1.

## Operation
- Reset values: all ready/valid/req outputs 0, `bresp`/`rresp` 2'b00, `rdata`/`wr_addr`/`wr_data`/`rd_addr` 0. On the first clock after reset release, `awready`/`wready`/`arready` go to 1.
- Address mapping: IPIF address = AXI address bits `[ADDR_WIDTH+1:2]`. Bits `[1:0]` and `*prot` are ignored.
- Write FSM states are `W_IDLE`, `W_REQ`, `W_WAIT`, `W_RESP`.
  - `W_IDLE`: AW and W are captured independently in any order or in the same cycle. Each ready drops once its channel has been captured. When both are held, go to `W_REQ`.
  - `W_REQ`: `wr_req`=1 for exactly one cycle with `wr_addr`/`wr_data` valid, then go to `W_WAIT`. If `wstrb` != 4'hF, skip `wr_req` and go straight to `W_RESP` with SLVERR.
  - `W_WAIT`: a cycle counter increments. `wr_ack`=1 goes to `W_RESP` with OKAY (2'b00). When the counter reaches `TIMEOUT`, go to `W_RESP` with SLVERR (2'b10).
  - `W_RESP`: `bvalid`=1 is held with `bresp` stable until `bready`. Then go to `W_IDLE` and re-raise `awready`/`wready`.
- Read FSM states are `R_IDLE`, `R_REQ`, `R_WAIT`, `R_RESP`.
  - `R_IDLE`: `arready`=1. The AR handshake latches `rd_addr`.
  - `R_REQ`: `rd_req` pulses for one cycle.
  - `R_WAIT`: `rd_ack` loads `rdata`←`rd_data` with OKAY. Timeout gives `rdata`=0 with SLVERR.
  - `R_RESP`: `rvalid` is held until `rready`.
- `wr_ack`/`rd_ack` are honoured in `*_REQ` (zero-latency ack) and in `*_WAIT`. In all other states they are ignored, so a late ack after a timeout is discarded.
- Write and read run concurrently; simultaneous `wr_req` and `rd_req` is legal. Only one outstanding transaction per direction.
- Reset mid-transaction: both FSMs return to IDLE immediately (asynchronously) and the outstanding transaction is dropped with no response.

## Timing
- Write, with AW/W handshake in cycle 0 and ack one cycle after req:
  - `wr_req` is high in cycle 1.
  - `wr_ack` is high in cycle 2.
  - `bvalid` is high from cycle 3.
  - `awready`/`wready` are high again in the cycle after the B handshake.
- Read: AR handshake in cycle 0, `rd_req` in cycle 1, `rd_ack` in cycle 2, `rvalid` from cycle 3.
- Timeout: `bvalid`/`rvalid` rise `TIMEOUT`+2 cycles after the address handshake when no ack arrives.
- Throughput: one write per 4 cycles and one read per 4 cycles with single-cycle ack and `bready`/`rready` held high.
- The `*_resp`, `rdata`, `wr_addr`, `wr_data` and `rd_addr` outputs are registered and change only on state transitions.

## Test plan
- Write `awaddr`=0x24 and `wdata`=0x0001_2345 in the same cycle, ack one cycle later → single `wr_req` pulse with `wr_addr`=9, `wr_data`=0x12345; `bvalid` in cycle 3 with `bresp`=00.
- W presented 4 cycles before AW (`awaddr`=0x800, `wdata`=0x1234) → `wready` drops after capture; exactly one `wr_req` with `wr_addr`=512 after AW arrives; `bresp`=00.
- `wstrb`=4'b0011 → no `wr_req`; `bresp`=10; the next full-strobe write completes with OKAY.
- Read `araddr`=0x0, `rd_ack` 2 cycles after `rd_req` with `rd_data`=0x0000_0005, `rready` low for 5 cycles → `rdata`=5, `rresp`=00, `rvalid` and `rdata` stable until `rready`, `arready` low throughout.
- Acks tied low, `TIMEOUT`=16 → `bresp`=10 and `rresp`=10 with `rdata`=0 at 18 cycles; an ack pulse arriving later is ignored; the following transactions with acks re-enabled complete with OKAY.
- `rst` asserted while in `W_WAIT` with a concurrent read in `R_WAIT` → all outputs go to reset values without waiting for a clock edge; no B/R response is issued; a write after release completes normally.
